// File: rtl/shake_load_ctrl.sv
// SHAKE input-load controller: paces message words into the SIPO and emits padding control.
// Optional SHAKE_LOAD_PERF_EN adds stall_cycles / blocks_loaded counters.
module shake_load_ctrl #(
    parameter int W             = 64,
    parameter int LEN_W         = 32,
    parameter int RATE128_BYTES = 168,
    parameter int RATE256_BYTES = 136
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_in,
    output logic                      ready_out,
    input  logic [LEN_W-1:0]          hdr_in_len,
    input  logic [LEN_W-1:0]          hdr_out_len,
    input  logic                      hdr_mode,
    output logic [LEN_W-1:0]          in_len_q,
    output logic [LEN_W-1:0]          out_len_q,
    output logic                      mode_q,
    input  logic                      input_buffer_empty,
    output logic                      load_enable,
    output logic [$clog2(W/8):0]      valid_bytes,
    output logic                      pad_domain,
    output logic                      pad_final,
    output logic                      buffer_ready_wr,
`ifdef SHAKE_LOAD_PERF_EN
    output logic [31:0]               stall_cycles,
    output logic [15:0]               blocks_loaded,
`endif
    output logic                      last_block_wr
);

    localparam int BPW    = W / 8;
    localparam int VB_W   = $clog2(BPW) + 1;
    localparam int RW128  = RATE128_BYTES / BPW;
    localparam int RW256  = RATE256_BYTES / BPW;
    localparam int RW_MAX = (RW128 > RW256) ? RW128 : RW256;
    localparam int IDX_W  = $clog2(RW_MAX);

    localparam logic [IDX_W-1:0] LAST128 = IDX_W'(RW128 - 1);
    localparam logic [IDX_W-1:0] LAST256 = IDX_W'(RW256 - 1);
    localparam logic [VB_W-1:0]  VB_FULL = VB_W'(BPW);

    typedef enum logic [1:0] {
        WAIT_HEADER,
        WAIT_BUF,
        LOAD,
        HANDOFF
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   bytes_left_q, bytes_left_d;
    logic [IDX_W-1:0]   word_idx_q, word_idx_d;
    logic               pad_started_q, pad_started_d;
    logic [LEN_W-1:0]   in_len_d, out_len_d;
    logic               mode_d;

    logic [IDX_W-1:0]   rw_last;
    logic               data_phase;

    always_comb begin
        state_d         = state_q;
        bytes_left_d    = bytes_left_q;
        word_idx_d      = word_idx_q;
        pad_started_d   = pad_started_q;
        in_len_d        = in_len_q;
        out_len_d       = out_len_q;
        mode_d          = mode_q;
        ready_out       = 1'b0;
        load_enable     = 1'b0;
        valid_bytes     = '0;
        pad_domain      = 1'b0;
        pad_final       = 1'b0;
        buffer_ready_wr = 1'b0;
        last_block_wr   = 1'b0;

        rw_last    = mode_q ? LAST256 : LAST128;
        data_phase = (bytes_left_q != '0);

        unique case (state_q)
            WAIT_HEADER: begin
                ready_out = 1'b1;
                if (valid_in) begin
                    in_len_d      = hdr_in_len;
                    out_len_d     = hdr_out_len;
                    mode_d        = hdr_mode;
                    bytes_left_d  = hdr_in_len;
                    pad_started_d = 1'b0;
                    state_d       = WAIT_BUF;
                end
            end
            WAIT_BUF: begin
                if (input_buffer_empty) begin
                    word_idx_d = '0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (data_phase) begin
                    ready_out   = 1'b1;
                    load_enable = valid_in;
                    if (bytes_left_q >= LEN_W'(BPW))
                        valid_bytes = VB_FULL;
                    else
                        valid_bytes = bytes_left_q[VB_W-1:0];
                end else begin
                    load_enable = 1'b1;
                end
                // Padding flags only mean something on a word that actually loads.
                if (load_enable) begin
                    pad_domain   = !pad_started_q && (valid_bytes < VB_FULL);
                    pad_final    = (word_idx_q == rw_last) &&
                                   (pad_started_q || pad_domain);
                    bytes_left_d = bytes_left_q - LEN_W'(valid_bytes);
                    if (pad_domain)
                        pad_started_d = 1'b1;
                    if (word_idx_q == rw_last)
                        state_d = HANDOFF;
                    else
                        word_idx_d = word_idx_q + IDX_W'(1);
                end
            end
            HANDOFF: begin
                buffer_ready_wr = 1'b1;
                last_block_wr   = pad_started_q;
                state_d         = pad_started_q ? WAIT_HEADER : WAIT_BUF;
            end
        endcase

        if (rst) begin
            ready_out       = 1'b0;
            load_enable     = 1'b0;
            valid_bytes     = '0;
            pad_domain      = 1'b0;
            pad_final       = 1'b0;
            buffer_ready_wr = 1'b0;
            last_block_wr   = 1'b0;
            state_d         = WAIT_HEADER;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WAIT_HEADER;
            bytes_left_q  <= '0;
            word_idx_q    <= '0;
            pad_started_q <= 1'b0;
            in_len_q      <= '0;
            out_len_q     <= '0;
            mode_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bytes_left_q  <= bytes_left_d;
            word_idx_q    <= word_idx_d;
            pad_started_q <= pad_started_d;
            in_len_q      <= in_len_d;
            out_len_q     <= out_len_d;
            mode_q        <= mode_d;
        end
    end

`ifdef SHAKE_LOAD_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] blocks_loaded_q, blocks_loaded_d;

    always_comb begin
        stall_cycles_d  = stall_cycles_q;
        blocks_loaded_d = blocks_loaded_q;
        if (state_q == LOAD && data_phase && !valid_in &&
            stall_cycles_q != '1)
            stall_cycles_d = stall_cycles_q + 32'd1;
        if (buffer_ready_wr && blocks_loaded_q != '1)
            blocks_loaded_d = blocks_loaded_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q  <= '0;
            blocks_loaded_q <= '0;
        end else begin
            stall_cycles_q  <= stall_cycles_d;
            blocks_loaded_q <= blocks_loaded_d;
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign blocks_loaded = blocks_loaded_q;
`endif

endmodule

// File: tb/tb_shake_load_ctrl.sv
// Self-checking bench for shake_load_ctrl (W=64) against a word-list model of FIPS-202 padding.
// Counter outputs are checked when SHAKE_LOAD_PERF_EN is defined.
module tb_shake_load_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] hdr_in_len;
    logic [31:0] hdr_out_len;
    logic        hdr_mode;
    logic [31:0] in_len_q;
    logic [31:0] out_len_q;
    logic        mode_q;
    logic        input_buffer_empty;
    logic        load_enable;
    logic [3:0]  valid_bytes;
    logic        pad_domain;
    logic        pad_final;
    logic        buffer_ready_wr;
    logic        last_block_wr;
`ifdef SHAKE_LOAD_PERF_EN
    logic [31:0] stall_cycles;
    logic [15:0] blocks_loaded;
`endif

    always #5 clk = ~clk;

    shake_load_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .valid_in           (valid_in),
        .ready_out          (ready_out),
        .hdr_in_len         (hdr_in_len),
        .hdr_out_len        (hdr_out_len),
        .hdr_mode           (hdr_mode),
        .in_len_q           (in_len_q),
        .out_len_q          (out_len_q),
        .mode_q             (mode_q),
        .input_buffer_empty (input_buffer_empty),
        .load_enable        (load_enable),
        .valid_bytes        (valid_bytes),
        .pad_domain         (pad_domain),
        .pad_final          (pad_final),
        .buffer_ready_wr    (buffer_ready_wr),
`ifdef SHAKE_LOAD_PERF_EN
        .stall_cycles       (stall_cycles),
        .blocks_loaded      (blocks_loaded),
`endif
        .last_block_wr      (last_block_wr)
    );

    typedef struct {
        int vb;
        bit dom;
        bit fin;
        bit be;
    } wexp_t;

    wexp_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    m_stall = 0;
    int    m_blocks = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".ready_out"}, ready_out, 0);
        chk({tag, ".load_enable"}, load_enable, 0);
        chk({tag, ".valid_bytes"}, valid_bytes, 0);
        chk({tag, ".pad_domain"}, pad_domain, 0);
        chk({tag, ".pad_final"}, pad_final, 0);
        chk({tag, ".buffer_ready_wr"}, buffer_ready_wr, 0);
        chk({tag, ".last_block_wr"}, last_block_wr, 0);
    endtask

    // ph: 0 header, 1 waiting for buffer, 2 loading, 3 handoff, 4 done
    task automatic run_msg(input int len, input bit mode, input int vpct,
                           input int epct, input int vs_at, input int vs_n,
                           input int es_n, input int abort_at);
        int    rw = mode ? 17 : 21;
        int    total = rw * (len / (rw * 8) + 1);
        int    ph = 0;
        int    loaded = 0;
        int    xfers = 0;
        int    vs_left = vs_n;
        int    es_cnt = 0;
        int    cyc = 0;
        int    rem;
        bit    data_nxt;
        bit    ld;
        logic [31:0] olen = $urandom;
        wexp_t w;
        q.delete();
        for (int k = 0; k < total; k++) begin
            rem   = len - k * 8;
            w.vb  = (rem >= 8) ? 8 : ((rem > 0) ? rem : 0);
            w.dom = (k == len / 8);
            w.fin = (k == total - 1);
            w.be  = ((k % rw) == rw - 1);
            q.push_back(w);
        end
        while (ph != 4) begin
            @(negedge clk);
            if (cyc++ > 3000) begin
                n_cmp++;
                n_bad++;
                $error("FAIL timeout len=%0d observed=phase%0d expected=done",
                       len, ph);
                break;
            end
            if (abort_at >= 0 && ph == 2 && loaded == abort_at) begin
                rst = 1'b1;
                valid_in = 1'b1;
                input_buffer_empty = 1'b1;
                #1;
                chk_quiet("abort_rst");
                @(negedge clk);
                rst = 1'b0;
                valid_in = 1'b0;
                #1;
                chk("abort.ready_out", ready_out, 1);
                chk("abort.load_enable", load_enable, 0);
                chk("abort.in_len_q", in_len_q, 0);
                chk("abort.mode_q", mode_q, 0);
                m_stall = 0;
                m_blocks = 0;
                return;
            end
            data_nxt = (q.size() > 0) && (q[0].vb > 0);
            valid_in = 1'($urandom_range(0, 1));
            input_buffer_empty = 1'($urandom_range(0, 1));
            hdr_in_len = $urandom;
            hdr_out_len = $urandom;
            hdr_mode = 1'($urandom_range(0, 1));
            case (ph)
                0: begin
                    valid_in = 1'b1;
                    hdr_in_len = len;
                    hdr_out_len = olen;
                    hdr_mode = mode;
                end
                1: begin
                    input_buffer_empty = (es_cnt >= es_n) &&
                                         ($urandom_range(0, 99) >= epct);
                    es_cnt++;
                end
                2: if (data_nxt) begin
                    valid_in = ($urandom_range(0, 99) >= vpct);
                    if (xfers == vs_at && vs_left > 0) begin
                        valid_in = 1'b0;
                        vs_left--;
                    end
                end
                default: ;
            endcase
            #1;
            ld = (ph == 2) && (data_nxt ? valid_in : 1'b1);
            chk("ready_out", ready_out, (ph == 0) || (ph == 2 && data_nxt));
            chk("load_enable", load_enable, ld);
            chk("pad_domain", pad_domain, ld ? q[0].dom : 1'b0);
            chk("pad_final", pad_final, ld ? q[0].fin : 1'b0);
            if (ld)
                chk("valid_bytes", valid_bytes, q[0].vb);
            chk("buffer_ready_wr", buffer_ready_wr, ph == 3);
            chk("last_block_wr", last_block_wr, ph == 3 && q.size() == 0);
            if (ph == 2 && data_nxt && !valid_in)
                m_stall++;
            case (ph)
                0: ph = 1;
                1: if (input_buffer_empty) ph = 2;
                2: if (ld) begin
                    w = q.pop_front();
                    loaded++;
                    if (data_nxt) xfers++;
                    if (w.be) ph = 3;
                end
                3: begin
                    m_blocks++;
                    es_cnt = 0;
                    ph = (q.size() == 0) ? 4 : 1;
                end
                default: ;
            endcase
        end
        valid_in = 1'b0;
        @(negedge clk);
        #1;
        chk("idle.ready_out", ready_out, 1);
        chk("idle.load_enable", load_enable, 0);
        chk("in_len_q", in_len_q, len);
        chk("out_len_q", out_len_q, olen);
        chk("mode_q", mode_q, mode);
        chk("xfers", xfers, (len + 7) / 8);
    endtask

    task automatic chk_perf(input string tag);
`ifdef SHAKE_LOAD_PERF_EN
        chk({tag, ".stall_cycles"}, stall_cycles, m_stall);
        chk({tag, ".blocks_loaded"}, blocks_loaded, m_blocks);
`else
        if (tag.len() == 0) n_cmp++;
`endif
    endtask

    initial begin
        rst = 1'b1;
        valid_in = 1'b1;
        hdr_in_len = 32'd5;
        hdr_out_len = 32'd7;
        hdr_mode = 1'b1;
        input_buffer_empty = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_quiet("reset");
        @(negedge clk);
        rst = 1'b0;
        valid_in = 1'b0;
        #1;
        chk("reset.ready_out", ready_out, 1);
        chk("reset.in_len_q", in_len_q, 0);
        chk("reset.out_len_q", out_len_q, 0);
        chk("reset.mode_q", mode_q, 0);

        run_msg(0,   1'b1, 0, 0, -1, 0, 0, -1);
        run_msg(20,  1'b1, 0, 0, -1, 0, 0, -1);
        run_msg(136, 1'b1, 0, 0, -1, 0, 0, -1);
        run_msg(135, 1'b1, 0, 0, -1, 0, 0, -1);
        run_msg(100, 1'b1, 0, 0, -1, 0, 0, 5);
        run_msg(8,   1'b1, 0, 0, -1, 0, 0, -1);
        run_msg(200, 1'b0, 0, 0, 5, 3, 5, -1);
        chk_perf("perf_directed");
        for (int i = 0; i < 20; i++)
            run_msg($urandom_range(0, 400), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 50), $urandom_range(0, 50),
                    -1, 0, $urandom_range(0, 3), -1);
        chk_perf("perf_random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
